// File: rtl/fb_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter_if
//   Write channel between game-logic writers and the frame-buffer arbiter.
//   master : writer side (drives wr_valid/wr_addr/wr_data, sees wr_ready/wr_err)
//   slave  : arbiter side
// Signals
//   wr_valid  writer has a request
//   wr_ready  arbiter FIFO not full; push on wr_valid && wr_ready
//   wr_addr   image address (y*IMG_W + x)
//   wr_data   pixel to write
//   wr_err    1-cycle pulse when an out-of-range entry was dropped
// ---------------------------------------------------------------------------
interface fb_port_arbiter_if #(
  parameter int AW = 17,
  parameter int DW = 12
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;

  modport master (output wr_valid, wr_addr, wr_data, input wr_ready, wr_err);
  modport slave  (input wr_valid, wr_addr, wr_data, output wr_ready, wr_err);
endinterface

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
//   Shares one single-port 160x120 frame-buffer BRAM between the VGA display
//   read path and game-logic writers. Display reads own every 4th pixel clock
//   of active video; a small write FIFO and an optional clear engine use the
//   remaining cycles. clk is the 25 MHz pixel clock.
//
//   Build option: define FB_CLEAR_EN to include the full-buffer clear engine.
//   Without it clr_req/clr_color are ignored and clr_busy is tied low.
//
// Ports
//   clk, rst            pixel clock, asynchronous active-high reset
//   h_cnt, v_cnt        VGA timing counters
//   wr                  write channel (fb_port_arbiter_if.slave)
//   clr_req, clr_color  start a clear / colour to fill with
//   clr_busy            clear engine active
//   mem_en, mem_we, mem_addr, mem_wdata, mem_rdata
//                       BRAM port (1-cycle synchronous read)
//   pix_data            displayed pixel, held between reads
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int IMG_W      = 160,
  parameter int IMG_H      = 120,
  parameter int SHIFT      = 2,
  parameter int SCR_W      = 640,
  parameter int SCR_H      = 480,
  parameter int DW         = 12,
  parameter int AW         = 17,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  fb_port_arbiter_if.slave wr,
  input  logic          clr_req,
  input  logic [DW-1:0] clr_color,
  output logic          clr_busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] pix_data
);

  localparam int PIX_CNT = IMG_W * IMG_H;
  localparam int PW      = $clog2(FIFO_DEPTH);
  localparam int CW      = PW + 1;

  // ---------------------------------------------------------------------------
  // Display read slot: first pixel clock of each 4-pixel group in active video.
  // ---------------------------------------------------------------------------
  logic          rd_slot;
  logic [AW-1:0] rd_addr;

  assign rd_slot = (h_cnt < 10'(SCR_W)) && (v_cnt < 10'(SCR_H)) &&
                   (h_cnt[SHIFT-1:0] == '0);
  assign rd_addr = AW'(h_cnt >> SHIFT) + AW'(IMG_W) * AW'(v_cnt >> SHIFT);

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [AW-1:0] fifo_addr [FIFO_DEPTH];
  logic [DW-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, head_oor;

  assign push       = wr.wr_valid && wr.wr_ready;
  assign head_oor   = fifo_addr[rd_ptr] >= AW'(PIX_CNT);
  assign count_next = count + CW'(push) - CW'(pop);

  // NOTE: storage arrays are not reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= wr.wr_addr;
      fifo_data[wr_ptr] <= wr.wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wr.wr_ready <= 1'b1;
      wr.wr_err   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_next;
      // Registered from next occupancy so the writer never sees a stale "ready".
      wr.wr_ready <= (count_next != CW'(FIFO_DEPTH));
      wr.wr_err   <= pop && head_oor;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  logic          clr_wr;     // clear write granted this cycle
  logic [AW-1:0] clr_addr;
  logic [DW-1:0] clr_wdata;

`ifdef FB_CLEAR_EN
  localparam int CNT_W = $clog2(PIX_CNT);

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  clr_state_t       state, state_next;
  logic [CNT_W-1:0] clr_cnt;
  logic [DW-1:0]    clr_color_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else if (state == IDLE && clr_req) begin
      clr_cnt     <= '0;
      clr_color_q <= clr_color;
    end else if (clr_wr) begin
      clr_cnt     <= clr_cnt + 1'b1;
    end
  end

  // clr_req during CLEAR is deliberately ignored.
  always_comb begin
    state_next = state;
    clr_wr     = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_next = CLEAR;
      CLEAR: begin
        if (!rd_slot) begin
          clr_wr = 1'b1;
          if (clr_cnt == CNT_W'(PIX_CNT - 1)) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clr_busy  = (state == CLEAR);
  assign clr_addr  = AW'(clr_cnt);
  assign clr_wdata = clr_color_q;
`else
  logic unused_clr;

  assign unused_clr = ^{clr_req, clr_color};
  assign clr_busy   = 1'b0;
  assign clr_wr     = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
`endif

  // ---------------------------------------------------------------------------
  // Port mux: read slot > clear write > FIFO head > idle.
  // The port is combinational from the counters (reads keep their 2-cycle
  // latency), so reset is gated in here to park the BRAM immediately.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    pop       = 1'b0;
    if (!rst) begin
      if (rd_slot) begin
        mem_en   = 1'b1;
        mem_addr = rd_addr;
      end else if (clr_wr) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_addr;
        mem_wdata = clr_wdata;
      end else if (count != '0) begin
        pop = 1'b1;
        // Out-of-range entries are consumed without touching the BRAM.
        if (!head_oor) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = fifo_addr[rd_ptr];
          mem_wdata = fifo_data[rd_ptr];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display output register: BRAM data arrives one cycle after the slot and
  // is captured the cycle after that.
  // ---------------------------------------------------------------------------
  logic rd_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_d1    <= 1'b0;
      pix_data <= '0;
    end else begin
      rd_d1 <= rd_slot;
      if (rd_d1) pix_data <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_port_arbiter
//   Self-checking bench for fb_port_arbiter. Holds a BRAM model, drives the
//   VGA counters and writers, and compares the port against a queue-based
//   reference of committed writes and a delay-line model of displayed pixels.
// ---------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam int PIX = 160 * 120;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    h_cnt, v_cnt;
  logic          clr_req;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [DW-1:0] pix_data;

  fb_port_arbiter_if #(.AW(AW), .DW(DW)) wr_if ();

  fb_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .wr        (wr_if),
    .clr_req   (clr_req),
    .clr_color (clr_color),
    .clr_busy  (clr_busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .pix_data  (pix_data)
  );

  always #20 clk = ~clk;

  // BRAM model: single port, 1-cycle synchronous read.
  logic [DW-1:0] bram_m [1 << AW];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram_m[mem_addr] <= mem_wdata;
      else        mem_rdata        <= bram_m[mem_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit slot_of(input int h, input int v);
    return (h < 640) && (v < 480) && (h % 4 == 0);
  endfunction

  function automatic int addr_of(input int h, input int v);
    return h / 4 + 160 * (v / 4);
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  wr_t           exp_q [$];      // accepted in-range writes, commit order
  int            outstanding = 0; // accepted entries not yet committed/dropped
  int            err_exp  = 0;
  int            err_seen = 0;
  int            clr_cnt_m = 0;
  logic [DW-1:0] clr_color_m = '0;
  int            busy_cycles = 0;
  bit            hist_v [2];
  logic [DW-1:0] hist_d [2];
  logic [DW-1:0] exp_pix;

  // Accepted pushes, seen at the edge that performs them.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      outstanding = 0;
    end else if (wr_if.wr_valid && wr_if.wr_ready) begin
      outstanding++;
      if (int'(wr_if.wr_addr) < PIX) exp_q.push_back('{wr_if.wr_addr, wr_if.wr_data});
      else                           err_exp++;
    end
  end

  // Port monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      hist_v    = '{0, 0};
      exp_pix   = '0;
      clr_cnt_m = 0;
    end else begin
      bit  slot;
      int  a;
      wr_t e;
      slot = slot_of(int'(h_cnt), int'(v_cnt));
      a    = addr_of(int'(h_cnt), int'(v_cnt));
      if (slot) begin
        check("rd_en", 32'(mem_en), 32'd1);
        check("rd_we", 32'(mem_we), 32'd0);
        check("rd_addr", 32'(mem_addr), 32'(a));
      end else begin
        check("stray_rd", 32'(mem_en && !mem_we), 32'd0);
      end
      if (mem_en && mem_we) begin
        if (clr_busy) begin
          check("clr_addr", 32'(mem_addr), 32'(clr_cnt_m));
          check("clr_data", 32'(mem_wdata), 32'(clr_color_m));
          clr_cnt_m++;
        end else begin
          check("wr_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.addr));
            check("wr_data", 32'(mem_wdata), 32'(e.data));
            outstanding--;
          end
        end
      end
      if (clr_busy) busy_cycles++;
      if (wr_if.wr_err) begin
        err_seen++;
        outstanding--;
      end
      // Displayed pixel = BRAM content at slot time, two clocks later, held.
      if (hist_v[1]) exp_pix = hist_d[1];
      check("pix", 32'(pix_data), 32'(exp_pix));
      hist_v[1] = hist_v[0];
      hist_d[1] = hist_d[0];
      hist_v[0] = slot;
      hist_d[0] = slot ? bram_m[a] : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called at posedge+1)
  // ---------------------------------------------------------------------------
  bit scan_en = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (scan_en) begin
      if (h_cnt == 10'd799) begin
        h_cnt = '0;
        v_cnt = (v_cnt == 10'd524) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt = h_cnt + 10'd1;
      end
    end
  endtask

  task automatic push(input int addr, input logic [DW-1:0] data);
    bit ok = 0;
    wr_if.wr_valid = 1'b1;
    wr_if.wr_addr  = AW'(addr);
    wr_if.wr_data  = data;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = wr_if.wr_ready;
      tick();
    end
    wr_if.wr_valid = 1'b0;
    if (!ok) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && outstanding != 0; i++) tick();
    check("drain", 32'(outstanding), 32'd0);
  endtask

  task automatic start_at(input int h, input int v);
    scan_en = 0;
    h_cnt   = 10'(h);
    v_cnt   = 10'(v);
    scan_en = 1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    for (int i = 0; i < (1 << AW); i++) bram_m[i] = DW'($urandom);
    rst = 1'b1;
    h_cnt = '0;
    v_cnt = '0;
    clr_req = 1'b0;
    clr_color = '0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_addr = '0;
    wr_if.wr_data = '0;

    // Reset state, with counters sitting on a read slot.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_pix", 32'(pix_data), 32'd0);
    check("rst_wr_err", 32'(wr_if.wr_err), 32'd0);
    check("rst_clr_busy", 32'(clr_busy), 32'd0);
    check("rst_wr_ready", 32'(wr_if.wr_ready), 32'd1);

    // T1: h=8, v=4 -> address 162, pixel two clocks later.
    @(posedge clk); #1;
    rst = 1'b0;
    h_cnt = 10'd8;
    v_cnt = 10'd4;
    @(negedge clk);
    check("t1_en", 32'(mem_en), 32'd1);
    check("t1_we", 32'(mem_we), 32'd0);
    check("t1_addr", 32'(mem_addr), 32'd162);
    @(negedge clk);
    @(negedge clk);
    check("t1_pix", 32'(pix_data), 32'(bram_m[162]));

    // T2: four pushes fill the FIFO while every cycle is a read slot.
    @(posedge clk); #1;
    h_cnt = '0;
    v_cnt = '0;
    for (int i = 0; i < 4; i++) push(100 + 7 * i, DW'(12'h100 + i));
    @(negedge clk);
    check("t2_full", 32'(wr_if.wr_ready), 32'd0);
    tick();
    start_at(0, 0);
    push(5000, 12'hABC);
    drain();

    // T3: out-of-range entry is dropped with a single-cycle error pulse.
    e0 = err_seen;
    push(PIX, 12'h555);
    drain();
    check("t3_err_pulse", 32'(err_seen - e0), 32'd1);
    push(PIX - 1, 12'h0F0);
    drain();

`ifdef FB_CLEAR_EN
    // T4: full clear during vertical blanking, with a write queued behind it.
    start_at(0, 480);
    clr_cnt_m   = 0;
    busy_cycles = 0;
    clr_color_m = 12'hF00;
    clr_req     = 1'b1;
    clr_color   = 12'hF00;
    tick();
    clr_req   = 1'b0;
    clr_color = '0;
    push(777, 12'h123);
    for (int i = 0; i < 25000 && clr_busy; i++) tick();
    check("t4_busy_cycles", 32'(busy_cycles), 32'(PIX));
    check("t4_clr_writes", 32'(clr_cnt_m), 32'(PIX));
    check("t4_first", 32'(bram_m[0]), 32'h00000F00);
    check("t4_last", 32'(bram_m[PIX-1]), 32'h00000F00);
    drain();

    // T5: reset in the middle of a clear.
    start_at(0, 480);
    clr_cnt_m   = 0;
    clr_color_m = 12'h0A5;
    clr_req     = 1'b1;
    clr_color   = 12'h0A5;
    tick();
    clr_req = 1'b0;
    begin
      bit hit = 0;
      for (int i = 0; i < 3000 && !hit; i++) begin
        @(negedge clk);
        if (clr_busy && mem_we && mem_addr == AW'(1000)) hit = 1;
        else tick();
      end
      check("t5_reached_1000", 32'(hit), 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    check("t5_busy", 32'(clr_busy), 32'd0);
    check("t5_ready", 32'(wr_if.wr_ready), 32'd1);
    check("t5_mem_en", 32'(mem_en), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    check("t5_untouched", 32'(bram_m[1000]), 32'h00000F00);
    check("t5_partial", 32'(bram_m[999]), 32'h000000A5);
`else
    // T6: clear request has no effect; writes flow normally.
    clr_req   = 1'b1;
    clr_color = 12'hF00;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t6_busy", 32'(clr_busy), 32'd0);
      tick();
    end
    push(321, 12'h777);
    drain();
`endif

    // Random traffic from a random raster position.
    start_at($urandom_range(0, 799), $urandom_range(0, 524));
    for (int i = 0; i < 2000; i++) begin
      wr_if.wr_valid = 1'($urandom_range(0, 1));
      wr_if.wr_addr  = ($urandom_range(0, 15) == 0) ? AW'(PIX + $urandom_range(0, 5000))
                                                     : AW'($urandom_range(0, PIX - 1));
      wr_if.wr_data  = DW'($urandom);
      tick();
    end
    wr_if.wr_valid = 1'b0;
    drain();
    check("err_count", 32'(err_seen), 32'(err_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
